// File: rtl/player_move_scheduler.sv
// Game-level controller: arbitrates debounced buttons into one move per tick with
// auto-repeat, and sequences the player life cycle (idle, play, dying, game over).
module player_move_scheduler #(
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_RATE   = 3,
    parameter int RESPAWN_TICKS = 16,
    parameter int START_LIVES   = 3
) (
    input  logic       btnClk,
    input  logic       rst,
    input  logic [3:0] btnRaw,
    input  logic       start,
    input  logic       playerDead,
    output logic [3:0] btns_o,
    output logic       playerDisable,
    output logic [2:0] lives,
    output logic [1:0] gameState,
    output logic       deathPulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [3:0] btns_q, btns_d;
    logic       dis_q, dis_d;
    logic       death_q, death_d;
    logic [7:0] rep_q, rep_d;
    logic [7:0] resp_q, resp_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] new_bits;

    // Fixed priority: up > down > right > left; result is one-hot or zero.
    function automatic logic [3:0] pick(input logic [3:0] b);
        if (b[3])      pick = 4'b1000;
        else if (b[2]) pick = 4'b0100;
        else if (b[1]) pick = 4'b0010;
        else if (b[0]) pick = 4'b0001;
        else           pick = 4'b0000;
    endfunction

    assign new_bits = btnRaw & ~prev_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        btns_d  = 4'b0000;
        death_d = 1'b0;
        rep_d   = rep_q;
        resp_d  = resp_q;
        prev_d  = 4'b0000;
        sel_d   = 4'b0000;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_PLAY;
                    lives_d = 3'(START_LIVES);
                    rep_d   = 8'd0;
                end
            end
            S_PLAY: begin
                if (playerDead) begin
                    state_d = S_DYING;
                    lives_d = (lives_q != 3'd0) ? 3'(lives_q - 3'd1) : 3'd0;
                    death_d = 1'b1;
                    resp_d  = 8'(RESPAWN_TICKS);
                    rep_d   = 8'd0;
                end else begin
                    prev_d = btnRaw;
                    sel_d  = sel_q;
                    if (new_bits != 4'b0000) begin
                        sel_d  = pick(new_bits);
                        btns_d = sel_d;
                        rep_d  = 8'(REPEAT_DELAY);
                    end else if ((sel_q & btnRaw) != 4'b0000) begin
                        if (rep_q <= 8'd1) begin
                            btns_d = sel_q;
                            rep_d  = 8'(REPEAT_RATE);
                        end else begin
                            rep_d = rep_q - 8'd1;
                        end
                    end else if (btnRaw != 4'b0000) begin
                        // Selected key released with others still held: hand over at once.
                        sel_d  = pick(btnRaw);
                        btns_d = sel_d;
                        rep_d  = 8'(REPEAT_DELAY);
                    end else begin
                        sel_d = 4'b0000;
                        rep_d = 8'd0;
                    end
                end
            end
            S_DYING: begin
                if (resp_q <= 8'd1) begin
                    resp_d  = 8'd0;
                    state_d = (lives_q == 3'd0) ? S_OVER : S_PLAY;
                end else begin
                    resp_d = resp_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // prev/sel default to zero outside PLAY, so entry into PLAY sees held keys as new.
        dis_d = (state_d != S_PLAY);
    end

    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lives_q <= 3'd0;
            btns_q  <= 4'b0000;
            dis_q   <= 1'b1;
            death_q <= 1'b0;
            rep_q   <= 8'd0;
            resp_q  <= 8'd0;
            prev_q  <= 4'b0000;
            sel_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            btns_q  <= btns_d;
            dis_q   <= dis_d;
            death_q <= death_d;
            rep_q   <= rep_d;
            resp_q  <= resp_d;
            prev_q  <= prev_d;
            sel_q   <= sel_d;
        end
    end

    assign btns_o        = btns_q;
    assign playerDisable = dis_q;
    assign lives         = lives_q;
    assign gameState     = state_q;
    assign deathPulse    = death_q;

endmodule

// File: tb/tb_player_move_scheduler.sv
// Bench for player_move_scheduler: table of per-tick vectors with expected outputs,
// plus hand-written sequences for asynchronous reset.
module tb_player_move_scheduler;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DYING = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    logic       btnClk;
    logic       rst;
    logic [3:0] btnRaw;
    logic       start;
    logic       playerDead;
    logic [3:0] btns_o;
    logic       playerDisable;
    logic [2:0] lives;
    logic [1:0] gameState;
    logic       deathPulse;

    typedef struct {
        logic [3:0] btn;
        logic       st;
        logic       dead;
        logic [3:0] e_btns;
        logic [1:0] e_state;
        logic [2:0] e_lives;
        logic       e_dis;
        logic       e_death;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    player_move_scheduler dut (
        .btnClk       (btnClk),
        .rst          (rst),
        .btnRaw       (btnRaw),
        .start        (start),
        .playerDead   (playerDead),
        .btns_o       (btns_o),
        .playerDisable(playerDisable),
        .lives        (lives),
        .gameState    (gameState),
        .deathPulse   (deathPulse)
    );

    initial begin
        btnClk = 1'b0;
        forever #5 btnClk = ~btnClk;
    end

    function automatic logic [10:0] pack(input logic [3:0] b, input logic [1:0] s,
                                         input logic [2:0] l, input logic d, input logic p);
        pack = {b, s, l, d, p};
    endfunction

    task automatic add(input logic [3:0] btn, input logic st, input logic dead,
                       input logic [3:0] eb, input logic [1:0] es, input logic [2:0] el,
                       input logic ed, input logic ep);
        vec_t v;
        v.btn = btn; v.st = st; v.dead = dead;
        v.e_btns = eb; v.e_state = es; v.e_lives = el; v.e_dis = ed; v.e_death = ep;
        vecs.push_back(v);
    endtask

    // One death in PLAY, 15 frozen ticks with noisy inputs, then the exit edge.
    task automatic add_death(input logic [2:0] l_after, input logic [1:0] exit_state);
        add(4'b0000, 1'b0, 1'b1, 4'b0000, ST_DYING, l_after, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++)
            add(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'b0000, ST_DYING, l_after, 1'b1, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 4'b0000, exit_state, l_after, exit_state != ST_PLAY, 1'b0);
    endtask

    task automatic check(input int idx);
        logic [10:0] got, exp;
        got = {btns_o, gameState, lives, playerDisable, deathPulse};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL step %0d: no expected entry queued", idx);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL step %0d: got btns=%0d state=%0d lives=%0d dis=%0d death=%0d, exp btns=%0d state=%0d lives=%0d dis=%0d death=%0d",
                         idx, got[10:7], got[6:5], got[4:2], got[1], got[0],
                         exp[10:7], exp[6:5], exp[4:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        btnRaw     = v.btn;
        start      = v.st;
        playerDead = v.dead;
        exp_q.push_back(pack(v.e_btns, v.e_state, v.e_lives, v.e_dis, v.e_death));
        @(posedge btnClk);
        #1;
        check(idx);
    endtask

    initial begin
        // Start, then up held for 20 ticks: pulses at 0, 8, 11, 14, 17; start ignored in PLAY.
        add(4'b0000, 1'b1, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            add(4'b1000, i == 5, 1'b0,
                (i == 0 || i == 8 || i == 11 || i == 14 || i == 17) ? 4'b1000 : 4'b0000,
                ST_PLAY, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        // Down+left together: down wins; release down: left immediately, then after 8 ticks.
        add(4'b0101, 1'b0, 1'b0, 4'b0100, ST_PLAY, 3'd3, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++)
            add(4'b0001, 1'b0, 1'b0, (j == 0 || j == 8) ? 4'b0001 : 4'b0000,
                ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b1111, 1'b0, 1'b0, 4'b1000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0110, 1'b0, 1'b0, 4'b0100, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        // Death with a button pressed at the same edge: death wins, no move.
        add(4'b1000, 1'b0, 1'b1, 4'b0000, ST_DYING, 3'd2, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++)
            add(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'b0000, ST_DYING, 3'd2, 1'b1, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd2, 1'b0, 1'b0);
        // Key held across respawn counts as newly pressed.
        add(4'b0010, 1'b0, 1'b0, 4'b0010, ST_PLAY, 3'd2, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd2, 1'b0, 1'b0);
        add_death(3'd1, ST_PLAY);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd1, 1'b0, 1'b0);
        add_death(3'd0, ST_OVER);
        for (int i = 0; i < 3; i++)
            add(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
                4'b0000, ST_OVER, 3'd0, 1'b1, 1'b0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0001, 1'b0, 1'b0, 4'b0001, ST_PLAY, 3'd3, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, ST_PLAY, 3'd3, 1'b0, 1'b0);

        // Reset values appear before any clock edge.
        rst = 1'b1; btnRaw = 4'b0000; start = 1'b0; playerDead = 1'b0;
        #3;
        exp_q.push_back(pack(4'b0000, ST_IDLE, 3'd0, 1'b1, 1'b0));
        check(-1);
        @(posedge btnClk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset mid-DYING with the respawn counter at 7.
        begin
            vec_t v;
            v.btn = 4'b0000; v.st = 1'b0; v.dead = 1'b1;
            v.e_btns = 4'b0000; v.e_state = ST_DYING; v.e_lives = 3'd2; v.e_dis = 1'b1; v.e_death = 1'b1;
            apply(v, 1000);
            v.dead = 1'b0; v.e_death = 1'b0;
            for (int k = 0; k < 9; k++) apply(v, 1001 + k);
            #2;
            rst = 1'b1;
            #1;
            exp_q.push_back(pack(4'b0000, ST_IDLE, 3'd0, 1'b1, 1'b0));
            check(1010);
            @(posedge btnClk);
            #1;
            rst = 1'b0;
            v.btn = 4'b0100; v.st = 1'b0; v.dead = 1'b0;
            v.e_btns = 4'b0000; v.e_state = ST_IDLE; v.e_lives = 3'd0; v.e_dis = 1'b1; v.e_death = 1'b0;
            apply(v, 1011);
            v.btn = 4'b0000; v.st = 1'b1;
            v.e_state = ST_PLAY; v.e_lives = 3'd3; v.e_dis = 1'b0;
            apply(v, 1012);
            v.btn = 4'b0100; v.st = 1'b0; v.e_btns = 4'b0100;
            apply(v, 1013);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/player_move_scheduler.md
# player_move_scheduler

Game-level controller that sits between the debounced push-buttons and the player rectangle block. It arbitrates simultaneous button presses into a single move command per tick and generates auto-repeat for held buttons. It also sequences the player life cycle (idle, play, dying/respawn, game over), driving the player block's `btns` and `playerDisable` inputs from its `player_dead` output.

## Interface
- `REPEAT_DELAY`, default 8: btnClk ticks from the first move pulse to the first auto-repeat pulse; range 1..255.
- `REPEAT_RATE`, default 3: btnClk ticks between successive auto-repeat pulses; range 1..255.
- `RESPAWN_TICKS`, default 16: ticks spent in DYING with the player frozen; range 1..255.
- `START_LIVES`, default 3: lives loaded on game start; range 1..7.
- `btnClk`  in  1  game tick clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btnRaw`  in  4  debounced buttons: [3]=up, [2]=down, [1]=right, [0]=left.
- `start`  in  1  start/restart request, level-sampled.
- `playerDead`  in  1  player-boxed-in flag from the player block, level-sampled.
- `btns_o`  out  4  registered move command to the player block: 8=up, 4=down, 2=right, 1=left, 0=none; never more than one bit set.
- `playerDisable`  out  1  registered; 1 freezes the player block.
- `lives`  out  3  remaining lives.
- `gameState`  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER.
- `deathPulse`  out  1  one-cycle strobe on each death.

## Operation
- Reset values: gameState=IDLE, lives=0, btns_o=0, playerDisable=1, deathPulse=0. All internal counters, the previous-button register and the selected direction are cleared.
- FSM:
  - IDLE: start=1 → PLAY, lives←START_LIVES.
  - PLAY: playerDead=1 → DYING, lives←lives−1, deathPulse=1 for that cycle, respawn counter←RESPAWN_TICKS. playerDead takes priority over any button that cycle; btns_o=0.
  - DYING: counter decrements each tick. When it reaches 0: lives==0 → OVER, else → PLAY. playerDead and start are ignored.
  - OVER: start=1 → PLAY, lives←START_LIVES.
  - start is ignored in PLAY and DYING.
- playerDisable=0 only in PLAY; it is 1 in every other state.
- btns_o is 0 in every state except PLAY.
- Direction select (PLAY only): newly pressed bits = btnRaw & ~btnPrev.
  - Any newly pressed bit: select the highest-priority new bit (up > down > right > left), emit its code this tick, and load the repeat counter with REPEAT_DELAY.
  - Else, if the selected bit is still held: decrement the repeat counter. When it reaches 0, emit the code and reload the counter with REPEAT_RATE.
  - Else, if the selected bit was released while other bits are held: select the highest-priority held bit, emit its code immediately, and load REPEAT_DELAY.
  - No bits held: selection cleared, no emission.
- Entering PLAY (from IDLE, OVER or DYING) clears the selection; a button already held at entry is treated as newly pressed.
- Counters are 8-bit; lives is 3-bit and never decrements below 0.

## Timing
- Single clock domain. All outputs are registered, with no combinational path from input to output.
- Edge-detected press sampled at edge n → btns_o holds the code for exactly the cycle after edge n, and returns to 0 at edge n+1 unless a repeat fires then.
- Held button first pulse at edge n → repeats at edges n+REPEAT_DELAY, then n+REPEAT_DELAY+k·REPEAT_RATE.
- Death: playerDead high at edge n in PLAY → at edge n, gameState=DYING, playerDisable=1, deathPulse=1, lives decremented. deathPulse=0 at n+1.
- Exit from DYING: PLAY or OVER at edge n+RESPAWN_TICKS.
- start sampled at edge n in IDLE or OVER → PLAY and playerDisable=0 after edge n.
- Asynchronous rst at any point, including mid-DYING or mid-repeat, forces reset values immediately. The first post-reset edge with rst low evaluates IDLE.

## Test plan
- Reset, then start=1 for one tick → gameState=1, lives=3, playerDisable=0, btns_o=0.
- btnRaw=4'b1000 held 20 ticks (defaults) → btns_o=8 at ticks 0, 8, 11, 14, 17 and 0 elsewhere; release → no further pulses.
- btnRaw goes 0→4'b0101 in one edge → btns_o=4 (down wins). Release down while left stays held → btns_o=1 the next tick, then repeat after 8 ticks.
- In PLAY, playerDead=1 for one tick → deathPulse single cycle, lives 3→2, playerDisable=1 for 16 ticks. Buttons pressed during DYING produce btns_o=0. Back to PLAY at tick 16.
- Three deaths → lives=0, gameState=3 after respawn count. start=1 → PLAY with lives=3.
- Assert rst mid-DYING with counter at 7 → immediately IDLE, lives=0, deathPulse=0, playerDisable=1. After release, start=1 → normal PLAY.
